approx_sum_normalizer: RTL and testbench

Post-addition normalization stage placed directly downstream of the approximate adder in the floating-point datapath. It accepts the W+1-bit raw sum (carry bit included) plus the operand exponent, left- or right-shifts the sum until the hidden-bit position W-1 holds the leading one, and adjusts the exponent to match. It flags zero, underflow and overflow, and hands the result to the rounding stage over a valid/ready handshake.

---
 rtl/approx_sum_normalizer_if.sv | 27 ++
 rtl/approx_sum_normalizer.sv | 115 +++++++++++
 tb/tb_approx_sum_normalizer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/approx_sum_normalizer_if.sv
// Handshake bundle between the approximate adder, the normalizer and the rounding stage.
interface approx_sum_normalizer_if #(
  parameter int unsigned W  = 11,
  parameter int unsigned EW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    sum;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    mant_out;
  logic [EW-1:0] exp_out;
  logic          zero;
  logic          unf;
  logic          ovf;

  modport master (
    output in_valid, sum, exp_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, zero, unf, ovf
  );

  modport slave (
    input  in_valid, sum, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, zero, unf, ovf
  );
endinterface

// File: rtl/approx_sum_normalizer.sv
// Post-add normalizer: moves the leading one to bit W-1 and adjusts the exponent.
// Define NORM_LZD_EN for the single-cycle leading-zero-count shifter.
module approx_sum_normalizer #(
  parameter int unsigned W  = 11,
  parameter int unsigned EW = 8
) (
  input logic                   clk,
  input logic                   rst,
  approx_sum_normalizer_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StShift, StOut} state_e;

  state_e        state_q, state_d;
  logic [W:0]    m_q, m_d;
  logic [EW-1:0] e_q, e_d;
  logic          zero_q, zero_d;
  logic          unf_q, unf_d;
  logic          ovf_q, ovf_d;

`ifdef NORM_LZD_EN
  int unsigned lz;
  int unsigned sh;

  // Leading-zero count of m[W-1:0]; shift is clamped by the exponent.
  always_comb begin
    lz = W;
    for (int i = 0; i < int'(W); i++) begin
      if (m_q[i]) lz = W - 1 - unsigned'(i);
    end
    sh = (lz > 32'(e_q)) ? 32'(e_q) : lz;
  end
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          m_d     = bus_io.sum;
          e_d     = bus_io.exp_in;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (m_q[W]) begin
          m_d = m_q >> 1;
          if (e_q == '1) ovf_d = 1'b1;
          else           e_d   = e_q + EW'(1);
          state_d = StOut;
        end else if (m_q == '0) begin
          zero_d  = 1'b1;
          e_d     = '0;
          state_d = StOut;
`ifdef NORM_LZD_EN
        end else begin
          m_d     = m_q << sh;
          e_d     = e_q - EW'(sh);
          unf_d   = (lz > 32'(e_q));
          state_d = StOut;
        end
`else
        end else if (m_q[W-1]) begin
          state_d = StOut;
        end else if (e_q == '0) begin
          unf_d   = 1'b1;
          state_d = StOut;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - EW'(1);
        end
`endif
      end
      StOut: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      e_q     <= '0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StOut);
  assign bus_io.mant_out  = m_q;
  assign bus_io.exp_out   = e_q;
  assign bus_io.zero      = zero_q;
  assign bus_io.unf       = unf_q;
  assign bus_io.ovf       = ovf_q;

endmodule

// File: tb/tb_approx_sum_normalizer.sv
// Directed bench for approx_sum_normalizer (W=11, EW=8); latency expectations follow NORM_LZD_EN.
module tb_approx_sum_normalizer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   lat;

  approx_sum_normalizer_if #(.W(11), .EW(8)) bus ();

  approx_sum_normalizer #(.W(11), .EW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NORM_LZD_EN
  localparam int LatShift = 1;
  localparam int LatUnf   = 1;
`else
  localparam int LatShift = 7;
  localparam int LatUnf   = 4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one input at the next edge and count edges until out_valid rises.
  task automatic send(input logic [11:0] s, input logic [7:0] ex, output int l);
    bus.in_valid = 1'b1;
    bus.sum      = s;
    bus.exp_in   = ex;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sum       = '0;
    bus.exp_in    = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mant", 32'(bus.mant_out), 32'h0);
    chk("rst_exp", 32'(bus.exp_out), 32'h0);
    chk("rst_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Already normalized
    send(12'h400, 8'd20, lat);
    chk("norm_lat", 32'(lat), 32'd1);
    chk("norm_mant", 32'(bus.mant_out), 32'h400);
    chk("norm_exp", 32'(bus.exp_out), 32'd20);
    chk("norm_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h0);
    chk("norm_in_ready", 32'(bus.in_ready), 32'd0);
    drain();

    // Carry
    send(12'h801, 8'd20, lat);
    chk("carry_lat", 32'(lat), 32'd1);
    chk("carry_mant", 32'(bus.mant_out), 32'h400);
    chk("carry_exp", 32'(bus.exp_out), 32'd21);
    chk("carry_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h0);
    drain();

    // Carry with saturated exponent
    send(12'h801, 8'hFF, lat);
    chk("ovf_lat", 32'(lat), 32'd1);
    chk("ovf_mant", 32'(bus.mant_out), 32'h400);
    chk("ovf_exp", 32'(bus.exp_out), 32'hFF);
    chk("ovf_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h1);
    drain();

    // Left shift by 6
    send(12'h010, 8'd20, lat);
    chk("shl_lat", 32'(lat), 32'(LatShift));
    chk("shl_mant", 32'(bus.mant_out), 32'h400);
    chk("shl_exp", 32'(bus.exp_out), 32'd14);
    chk("shl_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h0);
    drain();

    // Zero sum
    send(12'h000, 8'd50, lat);
    chk("zero_lat", 32'(lat), 32'd1);
    chk("zero_mant", 32'(bus.mant_out), 32'h0);
    chk("zero_exp", 32'(bus.exp_out), 32'h0);
    chk("zero_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h4);
    drain();

    // Underflow: exponent runs out after 3 shifts
    send(12'h001, 8'd3, lat);
    chk("unf_lat", 32'(lat), 32'(LatUnf));
    chk("unf_mant", 32'(bus.mant_out), 32'h008);
    chk("unf_exp", 32'(bus.exp_out), 32'h0);
    chk("unf_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h2);
    drain();

    // Normalized input with exponent already 0 is not an underflow
    send(12'h7FF, 8'd0, lat);
    chk("e0_mant", 32'(bus.mant_out), 32'h7FF);
    chk("e0_flags", 32'({bus.zero, bus.unf, bus.ovf}), 32'h0);
    drain();

    // Back-pressure with a competing input offered
    bus.out_ready = 1'b0;
    send(12'h400, 8'd20, lat);
    chk("bp_lat", 32'(lat), 32'd1);
    bus.in_valid = 1'b1;
    bus.sum      = 12'h001;
    bus.exp_in   = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_mant", 32'(bus.mant_out), 32'h400);
      chk("bp_exp", 32'(bus.exp_out), 32'd20);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_mant", 32'(bus.mant_out), 32'h400);

    // Reset during the third SHIFT cycle
    bus.in_valid = 1'b1;
    bus.sum      = 12'h010;
    bus.exp_in   = 8'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) lat++;
    end
    chk("rst_no_result", 32'(lat), 32'd0);

    // Recovery after reset
    send(12'h801, 8'd20, lat);
    chk("post_rst_exp", 32'(bus.exp_out), 32'd21);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_fail);
    $finish;
  end

endmodule
